// File: rtl/flash_access_arbiter_if.sv
// Requester-side handshake bundle for the flash access arbiter.
// master = requester, slave = arbiter.
interface flash_access_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, err);
  modport slave  (input req, we, addr, wdata, output ack, err);
endinterface

// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter sharing one external flash port between two requesters,
// with a ready-wait timeout and registered per-requester ack/err pulses.
module flash_access_arbiter #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flash_access_arbiter_if.slave m0,
  flash_access_arbiter_if.slave m1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  owner,
  output logic [ADDR_W-1:0]     flash_addr,
  output logic [DATA_W-1:0]     flash_wdata,
  output logic                  flash_we,
  output logic                  flash_oe,
  output logic                  flash_ce,
  input  logic [DATA_W-1:0]     flash_rdata,
  input  logic                  flash_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t           state;
  state_t           next_state;
  logic             last_owner;
  logic             lat_we;
  logic [CNT_W-1:0] cnt;

  logic any_req;
  logic grant_m1;
  logic done_ok;
  logic done_to;

  logic ce_d, we_d, oe_d, busy_d;
  logic m0_ack_d, m0_err_d, m1_ack_d, m1_err_d;
  logic m0_ack_q, m0_err_q, m1_ack_q, m1_err_q;

  // m1 wins a tie only when m0 was served last
  assign any_req  = m0.req | m1.req;
  assign grant_m1 = m1.req & (~m0.req | ~last_owner);
  assign done_ok  = (state == ACCESS) & flash_ready;
  assign done_to  = (state == ACCESS) & ~flash_ready & (cnt == CNT_W'(TIMEOUT - 1));

  assign m0.ack = m0_ack_q;
  assign m0.err = m0_err_q;
  assign m1.ack = m1_ack_q;
  assign m1.err = m1_err_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (done_ok || done_to) next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so registered outputs align with it
  always_comb begin
    ce_d     = 1'b0;
    we_d     = 1'b0;
    oe_d     = 1'b0;
    busy_d   = 1'b0;
    m0_ack_d = 1'b0;
    m0_err_d = 1'b0;
    m1_ack_d = 1'b0;
    m1_err_d = 1'b0;
    busy_d   = (next_state != IDLE);
    ce_d     = (next_state == SETUP) || (next_state == ACCESS);
    we_d     = (next_state == ACCESS) &  lat_we;
    oe_d     = (next_state == ACCESS) & ~lat_we;
    m0_ack_d = done_ok & ~owner;
    m1_ack_d = done_ok &  owner;
    m0_err_d = done_to & ~owner;
    m1_err_d = done_to &  owner;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flash_ce <= 1'b0;
      flash_we <= 1'b0;
      flash_oe <= 1'b0;
      busy     <= 1'b0;
      m0_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      flash_ce <= ce_d;
      flash_we <= we_d;
      flash_oe <= oe_d;
      busy     <= busy_d;
      m0_ack_q <= m0_ack_d;
      m0_err_q <= m0_err_d;
      m1_ack_q <= m1_ack_d;
      m1_err_q <= m1_err_d;
    end
  end

  // Transaction latch, timeout counter and read-data capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      lat_we      <= 1'b0;
      flash_addr  <= '0;
      flash_wdata <= '0;
      cnt         <= '0;
      rdata       <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner       <= grant_m1;
        lat_we      <= grant_m1 ? m1.we    : m0.we;
        flash_addr  <= grant_m1 ? m1.addr  : m0.addr;
        flash_wdata <= grant_m1 ? m1.wdata : m0.wdata;
      end
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
      if (done_ok && !lat_we) rdata <= flash_rdata;
      if (state == RECOVER) last_owner <= owner;
    end
  end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Directed bench for flash_access_arbiter: scoreboard of expected completions
// checked against ack/err pulses, plus cycle-level flash strobe checks.
module tb_flash_access_arbiter;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              owner;
  logic [ADDR_W-1:0] flash_addr;
  logic [DATA_W-1:0] flash_wdata;
  logic              flash_we;
  logic              flash_oe;
  logic              flash_ce;
  logic [DATA_W-1:0] flash_rdata;
  logic              flash_ready;

  flash_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  flash_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  flash_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .rdata       (rdata),
    .busy        (busy),
    .owner       (owner),
    .flash_addr  (flash_addr),
    .flash_wdata (flash_wdata),
    .flash_we    (flash_we),
    .flash_oe    (flash_oe),
    .flash_ce    (flash_ce),
    .flash_rdata (flash_rdata),
    .flash_ready (flash_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m1;
    logic        is_err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic m1, input logic is_err, input logic [31:0] rd);
    exp_t e;
    e.m1     = m1;
    e.is_err = is_err;
    e.rdata  = rd;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] pulses();
    return {m1_if.err, m1_if.ack, m0_if.err, m0_if.ack};
  endfunction

  // Compare the completion visible this cycle against the oldest expectation
  task automatic check_completion();
    exp_t       e;
    logic [3:0] want;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'(sb.size()), 64'd1);
      return;
    end
    e    = sb.pop_front();
    want = e.m1 ? (e.is_err ? 4'b1000 : 4'b0100) : (e.is_err ? 4'b0010 : 4'b0001);
    check("pulses", 64'(pulses()), 64'(want));
    check("owner_at_done", 64'(owner), 64'(e.m1));
    check("rdata_at_done", 64'(rdata), 64'(e.rdata));
    check("ce_at_done", 64'(flash_ce), 64'd0);
  endtask

  task automatic await_completion(input int budget, output int cycles, output int oe_n, output int we_n);
    logic hit;
    hit    = 1'b0;
    cycles = 0;
    oe_n   = 0;
    we_n   = 0;
    while (!hit && cycles < budget) begin
      tick();
      cycles++;
      if (pulses() != 4'b0000) hit = 1'b1;
      else begin
        oe_n += int'(flash_oe);
        we_n += int'(flash_we);
      end
    end
    if (!hit) check("await_timeout", 64'(hit), 64'd1);
  endtask

  initial begin
    int         cyc;
    int         oe_n;
    int         we_n;
    logic [3:0] seen;

    rst_n        = 1'b0;
    flash_ready  = 1'b0;
    flash_rdata  = '0;
    m0_if.req    = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req    = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_ce", 64'(flash_ce), 64'd0);
    check("rst_addr", 64'(flash_addr), 64'd0);
    check("rst_pulses", 64'(pulses()), 64'd0);

    // Single m0 read, ready already high
    rst_n       = 1'b1;
    flash_ready = 1'b1;
    flash_rdata = 32'hDEADBEEF;
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 24'h000100;
    push_exp(1'b0, 1'b0, 32'hDEADBEEF);
    tick();
    check("t1_setup_ce", 64'(flash_ce), 64'd1);
    check("t1_setup_oe", 64'(flash_oe), 64'd0);
    check("t1_setup_addr", 64'(flash_addr), 64'h000100);
    check("t1_setup_busy", 64'(busy), 64'd1);
    m0_if.req = 1'b0;
    tick();
    check("t1_access_ce", 64'(flash_ce), 64'd1);
    check("t1_access_oe", 64'(flash_oe), 64'd1);
    check("t1_access_we", 64'(flash_we), 64'd0);
    tick();
    check_completion();
    check("t1_recover_oe", 64'(flash_oe), 64'd0);
    tick();
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_idle_pulses", 64'(pulses()), 64'd0);

    // Both requesting continuously from reset: m0,m1,m0,m1
    rst_n       = 1'b0;
    flash_rdata = 32'hCAFEF00D;
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 24'h000200;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 24'h000300;
    tick();
    check("t2_rst_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(1'(i % 2), 1'b0, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      await_completion(20, cyc, oe_n, we_n);
      check_completion();
      check("t2_interval", 64'(cyc), (i == 0) ? 64'd3 : 64'd4);
      check("t2_oe_cycles", 64'(oe_n), 64'd1);
      if (i == 3) begin
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
      end
    end
    tick();
    tick();
    check("t2_quiet_busy", 64'(busy), 64'd0);

    // m1 write with ready held low for 5 access cycles
    flash_ready = 1'b0;
    flash_rdata = 32'h55AA55AA;
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 24'hABCDEF; m1_if.wdata = 32'h12345678;
    push_exp(1'b1, 1'b0, 32'hCAFEF00D);
    tick();
    check("t3_setup_we", 64'(flash_we), 64'd0);
    check("t3_setup_addr", 64'(flash_addr), 64'hABCDEF);
    check("t3_setup_wdata", 64'(flash_wdata), 64'h12345678);
    check("t3_setup_owner", 64'(owner), 64'd1);
    m1_if.req = 1'b0;
    we_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      we_n += int'(flash_we);
      if (i == 5) flash_ready = 1'b1;
    end
    tick();
    check_completion();
    check("t3_we_cycles", 64'(we_n), 64'd6);
    check("t3_recover_we", 64'(flash_we), 64'd0);
    flash_ready = 1'b0;
    tick();

    // m0 read that never sees ready: timeout after TIMEOUT access cycles
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 24'h000400;
    push_exp(1'b0, 1'b1, 32'hCAFEF00D);
    tick();
    m0_if.req = 1'b0;
    await_completion(30, cyc, oe_n, we_n);
    check_completion();
    check("t4_access_cycles", 64'(oe_n), 64'(TIMEOUT));
    check("t4_latency", 64'(cyc), 64'(TIMEOUT + 1));
    tick();
    check("t4_idle_busy", 64'(busy), 64'd0);
    check("t4_idle_pulses", 64'(pulses()), 64'd0);

    // Reset during an m1 write access
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 24'h000010; m1_if.wdata = 32'h0BADF00D;
    tick();
    m1_if.req = 1'b0;
    tick();
    check("t5_access_we", 64'(flash_we), 64'd1);
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_rst_ce", 64'(flash_ce), 64'd0);
    check("t5_rst_we", 64'(flash_we), 64'd0);
    check("t5_rst_oe", 64'(flash_oe), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_pulses", 64'(pulses()), 64'd0);
    rst_n = 1'b1;
    seen  = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= pulses();
    end
    check("t5_no_late_pulse", 64'(seen), 64'd0);

    // m1 request arriving while m0 is in ACCESS is served right after
    flash_ready = 1'b1;
    flash_rdata = 32'h600D0001;
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.addr = 24'h000500;
    push_exp(1'b0, 1'b0, 32'h600D0001);
    tick();
    m0_if.req = 1'b0;
    tick();
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.addr = 24'h000600;
    push_exp(1'b1, 1'b0, 32'h600D0002);
    tick();
    check_completion();
    flash_rdata = 32'h600D0002;
    tick();
    check("t6_idle_busy", 64'(busy), 64'd0);
    tick();
    check("t6_m1_setup_busy", 64'(busy), 64'd1);
    check("t6_m1_setup_ce", 64'(flash_ce), 64'd1);
    check("t6_m1_setup_owner", 64'(owner), 64'd1);
    check("t6_m1_setup_addr", 64'(flash_addr), 64'h000600);
    m1_if.req = 1'b0;
    await_completion(10, cyc, oe_n, we_n);
    check_completion();
    check("t6_m1_latency", 64'(cyc), 64'd2);
    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
